// File: rtl/imem_pkg.sv
// Shared constants and FSM state type for the instruction-memory responder.
package imem_pkg;
  localparam int          DEPTH_DEF = 1024;
  localparam logic [31:0] NOP       = 32'h0000_0000;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM: one write port, one registered read port on a shared address.
module imem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  // Array has no reset so a reset never disturbs the loaded program.
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/imem_resp.sv
// Instruction memory with a program-load phase followed by one-cycle-latency fetch responses.
module imem_resp
  import imem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] pc,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        ld_done,
  output logic        ready,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        fault,
  output logic [31:0] fetch_cnt
);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_e      state_q, state_d;
  logic        vld_q, vld_d;
  logic        fault_q, fault_d;
  logic        zero_q, zero_d;
  logic [31:0] cnt_q, cnt_d;

  logic          run;
  logic          fetch_fault;
  logic          we, re;
  logic [AW-1:0] addr;
  logic [31:0]   rdata;

  assign run         = (state_q == ST_RUN);
  assign fetch_fault = (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= DEPTH_W);
  assign we          = !run && ld_en && (ld_addr < DEPTH_W);
  assign re          = run && ce && !fetch_fault;
  assign addr        = run ? pc[AW+1:2] : ld_addr[AW-1:0];

  imem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .addr_i  (addr),
    .we_i    (we),
    .wdata_i (ld_data),
    .re_i    (re),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d = state_q;
    vld_d   = 1'b0;
    fault_d = 1'b0;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    if (!run) begin
      if (ld_done) state_d = ST_RUN;
    end else if (ce) begin
      vld_d   = 1'b1;
      fault_d = fetch_fault;
      // zero_q picks NOP over the RAM read register and persists while ce=0.
      zero_d  = fetch_fault;
      if (!fetch_fault && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      vld_q   <= 1'b0;
      fault_q <= 1'b0;
      zero_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      fault_q <= fault_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready      = run;
  assign inst       = zero_q ? NOP : rdata;
  assign inst_valid = vld_q;
  assign fault      = fault_q;
  assign fetch_cnt  = cnt_q;
endmodule
